// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared op and FSM encodings for the stack engine
package stack_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_NOP     = 3'd0;
    localparam op_t OP_PUSH    = 3'd1;
    localparam op_t OP_POP     = 3'd2;
    localparam op_t OP_PEEK    = 3'd3;
    localparam op_t OP_REPLACE = 3'd4;
    localparam op_t OP_DROPN   = 3'd5;
    localparam op_t OP_SCRUB   = 3'd6;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SCRUB = 1'b1;

endpackage

// File: rtl/stack_ram.sv
// rtl/stack_ram.sv - single-port stack store with scrub/datapath write mux
module stack_ram
    import stack_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              scrub_i,
    input  logic [AW-1:0]     scrub_addr_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] wdata;
    logic              we;

    // The scrub engine owns the single port while it runs and writes zeroes.
    always_comb begin
        addr  = scrub_i ? scrub_addr_i : addr_i;
        wdata = scrub_i ? '0 : wdata_i;
        we    = scrub_i | we_i;
    end

    // Synchronous write; contents are not reset, the scrub clears them.
    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Registered read; holds its last value between reads.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i && !scrub_i) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/stack_engine.sv
// rtl/stack_engine.sv - downward-growing hardware stack with scrub FSM
module stack_engine
    import stack_pkg::*;
#(
    parameter  int DATA_W = 16,
    parameter  int DEPTH  = 64,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              op_valid_i,
    input  logic [2:0]        op_i,
    input  logic [AW-1:0]     op_arg_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              err_clr_i,
    output logic              ready_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    output logic [AW:0]       sp_o,
    output logic [AW:0]       count_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              ovf_o,
    output logic              unf_o
);

    localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_V   = (AW+1)'(1);

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW:0]   sp_q, sp_d;
    logic          ovf_q, ovf_d, unf_q, unf_d;
    logic          rd_valid_q;
    logic          ovf_set, unf_set;
    logic          ram_we, ram_re;
    logic [AW-1:0] ram_addr;
    logic [AW:0]   count, arg_ext, sp_m1, sp_plus_arg;
    logic          accept, full, empty;

    assign count       = DEPTH_V - sp_q;
    assign full        = (sp_q == '0);
    assign empty       = (sp_q == DEPTH_V);
    assign arg_ext     = {1'b0, op_arg_i};
    assign sp_m1       = sp_q - ONE_V;
    assign sp_plus_arg = sp_q + arg_ext;
    assign accept      = op_valid_i && (state_q == ST_IDLE);

    // Next-state, pointer and memory-port decode; bounds checked before any access.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        sp_d     = sp_q;
        ovf_set  = 1'b0;
        unf_set  = 1'b0;
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        ram_addr = sp_q[AW-1:0];
        if (state_q == ST_SCRUB) begin
            idx_d = idx_q - 1'b1;
            if (idx_q == '0) begin
                state_d = ST_IDLE;
                sp_d    = DEPTH_V;
            end
        end else if (accept) begin
            case (op_i)
                OP_PUSH: begin
                    if (full) begin
                        ovf_set = 1'b1;
                    end else begin
                        ram_we   = 1'b1;
                        ram_addr = sp_m1[AW-1:0];
                        sp_d     = sp_m1;
                    end
                end
                OP_POP: begin
                    if (empty) begin
                        unf_set = 1'b1;
                    end else begin
                        ram_re = 1'b1;
                        sp_d   = sp_q + ONE_V;
                    end
                end
                OP_PEEK: begin
                    if (arg_ext < count) begin
                        ram_re   = 1'b1;
                        ram_addr = sp_plus_arg[AW-1:0];
                    end else begin
                        unf_set = 1'b1;
                    end
                end
                OP_REPLACE: begin
                    if (empty) begin
                        unf_set = 1'b1;
                    end else begin
                        ram_we = 1'b1;
                    end
                end
                OP_DROPN: begin
                    if (arg_ext <= count) begin
                        sp_d = sp_plus_arg;
                    end else begin
                        sp_d    = DEPTH_V;
                        unf_set = 1'b1;
                    end
                end
                OP_SCRUB: begin
                    state_d = ST_SCRUB;
                    idx_d   = {AW{1'b1}};
                end
                default: ;
            endcase
        end
        ovf_d = (ovf_q & ~err_clr_i) | ovf_set;
        unf_d = (unf_q & ~err_clr_i) | unf_set;
    end

    // Control state; reset restarts the scrub from the top index.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_SCRUB;
            idx_q      <= {AW{1'b1}};
            sp_q       <= DEPTH_V;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            sp_q       <= sp_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            rd_valid_q <= ram_re;
        end
    end

    stack_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .scrub_i      (state_q == ST_SCRUB),
        .scrub_addr_i (idx_q),
        .we_i         (ram_we),
        .re_i         (ram_re),
        .addr_i       (ram_addr),
        .wdata_i      (wr_data_i),
        .rdata_o      (rd_data_o)
    );

    assign ready_o    = (state_q == ST_IDLE);
    assign rd_valid_o = rd_valid_q;
    assign sp_o       = sp_q;
    assign count_o    = count;
    assign full_o     = full;
    assign empty_o    = empty;
    assign ovf_o      = ovf_q;
    assign unf_o      = unf_q;

endmodule

// File: tb/tb_stack_engine.sv
// tb/tb_stack_engine.sv - directed vector bench for stack_engine
module tb_stack_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [2:0]  op_arg = 3'd0;
    logic [15:0] wr_data = 16'h0;
    logic        err_clr = 1'b0;
    logic        ready, rd_valid, full, empty, ovf, unf;
    logic [15:0] rd_data;
    logic [3:0]  sp, count;

    int checks = 0;
    int failures = 0;
    logic [15:0] last_rd = 16'h0;

    always #5 clk = ~clk;

    stack_engine #(.DATA_W(16), .DEPTH(8)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .op_valid_i (op_valid),
        .op_i       (op),
        .op_arg_i   (op_arg),
        .wr_data_i  (wr_data),
        .err_clr_i  (err_clr),
        .ready_o    (ready),
        .rd_data_o  (rd_data),
        .rd_valid_o (rd_valid),
        .sp_o       (sp),
        .count_o    (count),
        .full_o     (full),
        .empty_o    (empty),
        .ovf_o      (ovf),
        .unf_o      (unf)
    );

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  arg;
        logic [15:0] wd;
        logic        clr;
        logic        rv;
        logic [15:0] rd;
        logic [3:0]  sp;
        logic [3:0]  cnt;
        logic        ovf;
        logic        unf;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic v(input logic [2:0] o, input logic [2:0] a, input logic [15:0] wd,
                     input logic clr, input logic rv, input logic [15:0] rd,
                     input logic [3:0] s, input logic [3:0] c, input logic ov, input logic un);
        vec_t t;
        t = '{o, a, wd, clr, rv, rd, s, c, ov, un};
        vecs.push_back(t);
    endtask

    task automatic do_op(input logic [2:0] o, input logic [2:0] a, input logic [15:0] wd, input logic clr);
        @(negedge clk);
        op = o; op_arg = a; wr_data = wd; err_clr = clr; op_valid = 1'b1;
        @(negedge clk);
        op_valid = 1'b0; err_clr = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    int n;

    initial begin
        // Reset state and post-reset scrub length.
        #13;
        chk("rst_ready", ready, 0);
        chk("rst_sp", sp, 8);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_flags", {ovf, unf}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready(n);
        chk("scrub_cycles", n, 8);
        chk("idle_sp", sp, 8);
        chk("idle_empty", empty, 1);
        chk("idle_count", count, 0);

        // op, arg, wdata, clr, rv, rd, sp, cnt, ovf, unf
        v(2, 0, 16'h0,    0, 0, 16'h0,    8, 0, 0, 1);
        v(0, 0, 16'h0,    1, 0, 16'h0,    8, 0, 0, 0);
        v(1, 0, 16'h1111, 0, 0, 16'h0,    7, 1, 0, 0);
        v(1, 0, 16'h2222, 0, 0, 16'h0,    6, 2, 0, 0);
        v(1, 0, 16'h3333, 0, 0, 16'h0,    5, 3, 0, 0);
        v(2, 0, 16'h0,    0, 1, 16'h3333, 6, 2, 0, 0);
        v(5, 2, 16'h0,    0, 0, 16'h0,    8, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            v(1, 0, 16'hA000 + 16'(i), 0, 0, 16'h0, 4'(7 - i), 4'(i + 1), 0, 0);
        v(1, 0, 16'hBEEF, 0, 0, 16'h0,    0, 8, 1, 0);
        v(3, 7, 16'h0,    0, 1, 16'hA000, 0, 8, 1, 0);
        v(3, 0, 16'h0,    0, 1, 16'hA007, 0, 8, 1, 0);
        v(7, 3, 16'h9999, 0, 0, 16'h0,    0, 8, 1, 0);
        v(0, 0, 16'h0,    1, 0, 16'h0,    0, 8, 0, 0);
        v(1, 0, 16'hBEEF, 1, 0, 16'h0,    0, 8, 1, 0);
        v(0, 0, 16'h0,    1, 0, 16'h0,    0, 8, 0, 0);
        v(5, 7, 16'h0,    0, 0, 16'h0,    7, 1, 0, 0);
        v(5, 1, 16'h0,    0, 0, 16'h0,    8, 0, 0, 0);
        v(1, 0, 16'h0001, 0, 0, 16'h0,    7, 1, 0, 0);
        v(1, 0, 16'h0002, 0, 0, 16'h0,    6, 2, 0, 0);
        v(1, 0, 16'h0003, 0, 0, 16'h0,    5, 3, 0, 0);
        v(4, 0, 16'h00FF, 0, 0, 16'h0,    5, 3, 0, 0);
        v(3, 0, 16'h0,    0, 1, 16'h00FF, 5, 3, 0, 0);
        v(3, 2, 16'h0,    0, 1, 16'h0001, 5, 3, 0, 0);
        v(3, 3, 16'h0,    0, 0, 16'h0,    5, 3, 0, 1);
        v(0, 0, 16'h0,    1, 0, 16'h0,    5, 3, 0, 0);
        v(5, 2, 16'h0,    0, 0, 16'h0,    7, 1, 0, 0);
        v(5, 5, 16'h0,    0, 0, 16'h0,    8, 0, 0, 1);
        v(0, 0, 16'h0,    1, 0, 16'h0,    8, 0, 0, 0);
        v(5, 0, 16'h0,    0, 0, 16'h0,    8, 0, 0, 0);
        v(4, 0, 16'h1234, 0, 0, 16'h0,    8, 0, 0, 1);
        v(2, 0, 16'h0,    0, 0, 16'h0,    8, 0, 0, 1);
        v(0, 0, 16'h0,    1, 0, 16'h0,    8, 0, 0, 0);
        v(1, 0, 16'h5555, 0, 0, 16'h0,    7, 1, 0, 0);
        v(2, 0, 16'h0,    0, 1, 16'h5555, 8, 0, 0, 0);

        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].arg, vecs[i].wd, vecs[i].clr);
            if (vecs[i].rv) last_rd = vecs[i].rd;
            chk($sformatf("v%0d_rd_valid", i), rd_valid, vecs[i].rv);
            chk($sformatf("v%0d_rd_data", i), rd_data, last_rd);
            chk($sformatf("v%0d_sp", i), sp, vecs[i].sp);
            chk($sformatf("v%0d_count", i), count, vecs[i].cnt);
            chk($sformatf("v%0d_full", i), full, vecs[i].sp == 4'd0);
            chk($sformatf("v%0d_empty", i), empty, vecs[i].sp == 4'd8);
            chk($sformatf("v%0d_ovf", i), ovf, vecs[i].ovf);
            chk($sformatf("v%0d_unf", i), unf, vecs[i].unf);
            chk($sformatf("v%0d_ready", i), ready, 1);
        end

        // SCRUB op empties the stack but leaves error flags alone.
        do_op(1, 0, 16'h0A0A, 0);
        do_op(1, 0, 16'h0B0B, 0);
        do_op(3, 5, 16'h0, 0);
        chk("scrubop_unf_pre", unf, 1);
        @(negedge clk);
        op = 3'd6; op_valid = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
        chk("scrubop_busy", ready, 0);
        wait_ready(n);
        chk("scrubop_cycles", n, 8);
        chk("scrubop_sp", sp, 8);
        chk("scrubop_unf_kept", unf, 1);
        do_op(0, 0, 16'h0, 1);
        chk("scrubop_clr", unf, 0);

        // Reset in the middle of a commanded scrub.
        do_op(1, 0, 16'h0C01, 0);
        do_op(1, 0, 16'h0C02, 0);
        do_op(1, 0, 16'h0C03, 0);
        do_op(1, 0, 16'h0C04, 0);
        do_op(3, 0, 16'h0, 0);
        chk("mid_peek", rd_data, 16'h0C04);
        do_op(3, 7, 16'h0, 0);
        chk("mid_unf_pre", unf, 1);
        @(negedge clk);
        op = 3'd6; op_valid = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("async_ready", ready, 0);
        chk("async_sp", sp, 8);
        chk("async_rd_data", rd_data, 0);
        chk("async_rd_valid", rd_valid, 0);
        chk("async_flags", {ovf, unf}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (!ready && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (n == 2) begin op = 3'd1; wr_data = 16'hDEAD; op_valid = 1'b1; end
            if (n == 5) op_valid = 1'b0;
        end
        op_valid = 1'b0;
        chk("rescrub_cycles", n, 8);
        chk("rescrub_sp", sp, 8);
        do_op(3, 0, 16'h0, 0);
        chk("final_peek_unf", unf, 1);
        chk("final_peek_rv", rd_valid, 0);
        chk("final_sp", sp, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stack_engine.md
Name: stack_engine

Overview:
- Parametrised hardware stack for the next-generation datapath. Replaces the fixed 16-bit SP register and the shared-memory stack with a dedicated, downward-growing stack store.
- Supports push, pop, peek-at-offset, replace-top and drop-N operations.
- Provides full/empty status, occupancy and sticky overflow/underflow flags.
- Includes a scrub FSM that zeroes the store after reset or on command.

Parameters:
DATA_W, 16, width of each stack entry
DEPTH, 64, number of entries; must be a power of two, at least 4
AW, $clog2(DEPTH), derived localparam; not overridable

Ports:
clk  in  1  system clock; all state updates on the rising edge
reset  in  1  asynchronous, active-low reset
op_valid  in  1  operation request; accepted only when ready=1
op  in  3  0 NOP, 1 PUSH, 2 POP, 3 PEEK, 4 REPLACE, 5 DROPN, 6 SCRUB, 7 reserved (treated as NOP)
op_arg  in  AW  PEEK offset from top of stack (0 = top); DROPN count
wr_data  in  DATA_W  data for PUSH and REPLACE
ready  out  1  high when an operation can be accepted
rd_data  out  DATA_W  registered read result of POP or PEEK
rd_valid  out  1  one-cycle pulse marking rd_data valid
sp  out  AW+1  stack pointer; DEPTH = empty, 0 = full
count  out  AW+1  occupancy, equal to DEPTH - sp
full  out  1  sp == 0
empty  out  1  sp == DEPTH
ovf  out  1  sticky overflow error flag
unf  out  1  sticky underflow / bad-offset error flag
err_clr  in  1  clears ovf and unf on the next edge

Behaviour:
- Reset (reset=0, asynchronous): sp=DEPTH, rd_data=0, rd_valid=0, ovf=0, unf=0, ready=0, FSM=SCRUB with scrub index=DEPTH-1.
- FSM states:
  - SCRUB: one location is written to 0 per cycle, index DEPTH-1 down to 0. ready=0. After the write to index 0, go to IDLE. Scrub takes exactly DEPTH cycles; ready rises on the following cycle.
  - IDLE: ready=1. An op is accepted on an edge where op_valid=1 and ready=1.
- Storage: entry i is mem[i]. Top of stack is mem[sp]. Memory writes are synchronous. Reads are registered, so rd_data and rd_valid appear one cycle after acceptance.
- PUSH:
  - If not full: mem[sp-1]=wr_data and sp decrements.
  - If full: no write, sp unchanged, ovf set.
- POP:
  - If not empty: rd_data=mem[sp], rd_valid=1, sp increments.
  - If empty: rd_valid=0, sp unchanged, unf set.
- PEEK:
  - If op_arg < count: rd_data=mem[sp+op_arg], rd_valid=1, sp unchanged.
  - Otherwise: unf set and no rd_valid.
- REPLACE:
  - If not empty: mem[sp]=wr_data, sp unchanged.
  - If empty: unf set and no write.
- DROPN:
  - If op_arg <= count: sp += op_arg. DROPN 0 is a legal no-op.
  - Otherwise: sp=DEPTH and unf set (the stack is emptied).
- SCRUB op: enters the SCRUB state. On completion sp=DEPTH. Errors are not touched.
- NOP and code 7: no effect.
- Error flags: ovf and unf are sticky. If err_clr coincides with a new error on the same edge, the new error wins (flag stays 1).
- rd_valid is high for only one cycle per accepted POP or PEEK. rd_data holds its last value otherwise.
- Arithmetic: sp is AW+1 bits wide and never leaves the range [0, DEPTH]. The sp+op_arg address is computed in AW+1 bits, and bounds are checked before any memory access.
- op_valid while ready=0: ignored. Nothing is queued.
- Reset asserted mid-scrub or mid-operation: immediately returns to the reset values and restarts the scrub. Memory contents are don't-care until the scrub completes.
- full, empty and count are combinational decodes of the sp register.

Decomposition:
- Shared package stack_pkg holds:
  - the op encodings (OP_NOP .. OP_SCRUB)
  - the FSM state encoding (ST_IDLE, ST_SCRUB)
- One sub-module, stack_ram: a DEPTH x DATA_W single-port RAM with synchronous write and registered read, plus a write port muxed between the scrub engine and the op datapath.
- All control, pointer and error logic stays in stack_engine.

Test Plan (DEPTH=8, DATA_W=16):
1. Release reset: ready=0 for exactly 8 cycles, then ready=1 with sp=8, empty=1, count=0. Then POP -> unf=1, rd_valid stays 0.
2. PUSH 0x1111, 0x2222, 0x3333, then POP -> rd_data=0x3333 with rd_valid one cycle later; sp=6 and count=2.
3. Push 8 values 0xA000..0xA007 -> full=1, sp=0. 9th PUSH 0xBEEF -> ovf=1, sp stays 0. Then PEEK op_arg=7 -> rd_data=0xA000.
4. Stack holding 3 entries (top 0x0003): REPLACE 0x00FF then PEEK 0 -> 0x00FF. DROPN 2 -> count=1. DROPN 5 -> sp=8, unf=1. Then err_clr pulse -> ovf=0 and unf=0.
5. err_clr asserted on the same edge as an overflowing PUSH -> ovf remains 1.
6. Pull reset low during a SCRUB op issued with 4 entries stacked -> outputs return to reset values asynchronously. After release, 8 scrub cycles run, then PEEK 0 -> unf=1 and sp=8.
